// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : EX/MEM pipeline register and MEM stage of the RV32I core.
//                Latches EX results, drives a ready-handshake data bus,
//                places store lanes, extends sub-word loads, stalls on wait
//                states, and aborts accesses that wait too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX stage results and control
    input  logic [31:0] ALU_OUT_EX,
    input  logic [31:0] REG_DATA2_EX_FINAL,
    input  logic [31:0] PC_Branch_EX,
    input  logic        ZERO_EX,
    input  logic [4:0]  RD_EX,
    input  logic [2:0]  FUNCT3_EX,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        Branch_EX,
    input  logic        flush_ex,
    // data memory bus
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    // pipeline control
    output logic        mem_stall,
    // MEM stage results
    output logic [31:0] ALU_OUT_MEM,
    output logic [31:0] LOAD_DATA_MEM,
    output logic [4:0]  RD_MEM,
    output logic        RegWrite_MEM,
    output logic        MemtoReg_MEM,
    output logic [31:0] PC_Branch_MEM,
    output logic        PCSrc_MEM,
    // sticky error flags
    output logic        misalign_err,
    output logic        timeout_err
);

    // Wait counter must reach MAX_WAIT, so size it to hold that value.
    localparam int c_CNT_W = $clog2(MAX_WAIT + 1);

    // Access sequencing states
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_ERR  = 2'd2;

    // funct3 encodings of interest
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // ------------------------------------------------------------------
    // EX/MEM register fields
    // ------------------------------------------------------------------
    logic [31:0]        r_alu;
    logic [31:0]        r_store;
    logic [31:0]        r_pc_branch;
    logic               r_zero;
    logic [4:0]         r_rd;
    logic [2:0]         r_f3;
    logic               r_regwrite;
    logic               r_memtoreg;
    logic               r_memread;
    logic               r_memwrite;
    logic               r_branch;

    // Sequencer and error state
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_misalign_err;
    logic               r_timeout_err;

    // Decode of the access held in MEM
    logic               w_mem_op;
    logic               w_f3_legal;
    logic               w_misaligned;
    logic               w_bad_access;
    logic               w_in_err;
    logic               w_req;
    logic               w_stall;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;

    // EX/MEM register: advance unless stalled; a flush loads a bubble by
    // clearing the control bits only, data fields are don't-care then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu       <= 32'd0;
            r_store     <= 32'd0;
            r_pc_branch <= 32'd0;
            r_zero      <= 1'b0;
            r_rd        <= 5'd0;
            r_f3        <= 3'd0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_branch    <= 1'b0;
        end else if (!w_stall) begin
            r_alu       <= ALU_OUT_EX;
            r_store     <= REG_DATA2_EX_FINAL;
            r_pc_branch <= PC_Branch_EX;
            r_zero      <= ZERO_EX;
            r_rd        <= RD_EX;
            r_f3        <= FUNCT3_EX;
            if (flush_ex) begin
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_branch   <= 1'b0;
            end else begin
                r_regwrite <= RegWrite_EX;
                r_memtoreg <= MemtoReg_EX;
                r_memread  <= MemRead_EX;
                r_memwrite <= MemWrite_EX;
                r_branch   <= Branch_EX;
            end
        end
    end

    // Legal funct3 for the access kind; unsigned loads have no store form.
    always_comb begin
        w_f3_legal = 1'b0;
        case (r_f3)
            c_F3_B, c_F3_H, c_F3_W: w_f3_legal = 1'b1;
            c_F3_BU, c_F3_HU:       w_f3_legal = ~r_memwrite;
            default:                w_f3_legal = 1'b0;
        endcase
    end

    // Alignment, request and stall decode. A read+write op counts as a write.
    always_comb begin
        w_mem_op     = r_memread | r_memwrite;
        w_misaligned = ((r_f3[1:0] == 2'b01) && r_alu[0]) ||
                       ((r_f3[1:0] == 2'b10) && (r_alu[1:0] != 2'b00));
        w_bad_access = w_mem_op && (!w_f3_legal || w_misaligned);
        w_in_err     = (r_state == c_ERR);
        w_req        = w_mem_op && !w_bad_access && !w_in_err;
        w_stall      = w_req && !dmem_ready;
    end

    // Store lane placement: enables shifted to the byte offset, data
    // replicated across every lane so the memory picks the enabled ones.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = r_store;
        if (r_memwrite) begin
            case (r_f3[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << r_alu[1:0];
                    dmem_wdata = {4{r_store[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << r_alu[1:0];
                    dmem_wdata = {2{r_store[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = r_store;
                end
            endcase
        end
    end

    // Load extension: pick the addressed byte/half, then sign or zero extend.
    always_comb begin
        case (r_alu[1:0])
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_f3)
            c_F3_B:  LOAD_DATA_MEM = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  LOAD_DATA_MEM = {{16{w_half[15]}}, w_half};
            c_F3_BU: LOAD_DATA_MEM = {24'd0, w_byte};
            c_F3_HU: LOAD_DATA_MEM = {16'd0, w_half};
            default: LOAD_DATA_MEM = dmem_rdata;
        endcase
    end

    // Access sequencer: counts wait states and forces a one-cycle abort
    // once the memory has been waited on for MAX_WAIT cycles in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req && !dmem_ready) begin
                        r_state <= c_WAIT;
                        r_cnt   <= c_CNT_W'(1);
                    end
                end
                c_WAIT: begin
                    if (dmem_ready) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_W'(MAX_WAIT)) begin
                        // flag is raised on entry so it is visible during ERR
                        r_state       <= c_ERR;
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ERR: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky misalignment/illegal flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else if (w_bad_access) begin
            r_misalign_err <= 1'b1;
        end
    end

    // Output assignments. Writeback is suppressed for rejected or aborted
    // accesses so a bad load never corrupts the register file.
    always_comb begin
        dmem_req      = w_req;
        dmem_we       = w_req && r_memwrite;
        dmem_addr     = {r_alu[31:2], 2'b00};
        mem_stall     = w_stall;
        ALU_OUT_MEM   = r_alu;
        RD_MEM        = r_rd;
        RegWrite_MEM  = r_regwrite && !w_bad_access && !w_in_err;
        MemtoReg_MEM  = r_memtoreg;
        PC_Branch_MEM = r_pc_branch;
        PCSrc_MEM     = r_branch && r_zero;
        misalign_err  = r_misalign_err;
        timeout_err   = r_timeout_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Scoreboard bench for mem_access_stage. A driver issues
//                instructions and pushes expected completions; a memory
//                responder answers requests with chosen latencies; a monitor
//                pops and compares whenever an instruction leaves MEM.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALU_OUT_EX = '0, REG_DATA2_EX_FINAL = '0, PC_Branch_EX = '0;
    logic        ZERO_EX = 1'b0;
    logic [4:0]  RD_EX = '0;
    logic [2:0]  FUNCT3_EX = '0;
    logic        RegWrite_EX = 1'b0, MemtoReg_EX = 1'b0, MemRead_EX = 1'b0;
    logic        MemWrite_EX = 1'b0, Branch_EX = 1'b0, flush_ex = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall;
    logic [31:0] ALU_OUT_MEM, LOAD_DATA_MEM, PC_Branch_MEM;
    logic [4:0]  RD_MEM;
    logic        RegWrite_MEM, MemtoReg_MEM, PCSrc_MEM, misalign_err, timeout_err;

    mem_access_stage #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALU_OUT_EX(ALU_OUT_EX), .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL),
        .PC_Branch_EX(PC_Branch_EX), .ZERO_EX(ZERO_EX), .RD_EX(RD_EX),
        .FUNCT3_EX(FUNCT3_EX), .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX),
        .flush_ex(flush_ex),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .ALU_OUT_MEM(ALU_OUT_MEM), .LOAD_DATA_MEM(LOAD_DATA_MEM), .RD_MEM(RD_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .PC_Branch_MEM(PC_Branch_MEM), .PCSrc_MEM(PCSrc_MEM),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          bubble;
        bit          access;
        bit          timeout;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          is_load;
        logic [31:0] load;
        bit          regwrite;
        bit          memtoreg;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pcb;
        bit          pcsrc;
        int          stalls;
        bit          mis;
        bit          tmo;
    } exp_t;

    exp_t        exp_q[$];
    int          lat_q[$];
    logic [31:0] rdata_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;
    bit m_mis  = 1'b0;
    bit m_tmo  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Issue one instruction: predict its completion from the access rules,
    // queue the prediction and memory behaviour, then hold it until taken.
    task automatic issue(input logic [31:0] alu, input logic [31:0] d, input logic [2:0] f3,
                         input bit rd_en, input bit wr, input bit rw, input bit mtr,
                         input bit br, input bit z, input logic [4:0] rd,
                         input logic [31:0] pcb, input bit flush, input int lat,
                         input logic [31:0] rdata);
        exp_t        e;
        int          size, off, guard;
        bit          memop, legal, bad, st;
        logic [31:0] sh;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(alu[1:0]);
        memop = !flush && (rd_en || wr);
        if (wr) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bad   = memop && !(legal && ((off % size) == 0));
        e.bubble  = flush;
        e.access  = memop && !bad;
        e.timeout = e.access && (lat > MAXW);
        e.stalls  = !e.access ? 0 : (e.timeout ? MAXW + 1 : lat);
        e.we      = wr;
        e.addr    = {alu[31:2], 2'b00};
        e.be      = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
        e.wdata   = (size == 1) ? {4{d[7:0]}} : (size == 2) ? {2{d[15:0]}} : d;
        e.is_load = e.access && !wr && !e.timeout;
        sh        = rdata >> (8 * off);
        case (f3)
            3'd0:    e.load = {{24{sh[7]}}, sh[7:0]};
            3'd1:    e.load = {{16{sh[15]}}, sh[15:0]};
            3'd4:    e.load = {24'd0, sh[7:0]};
            3'd5:    e.load = {16'd0, sh[15:0]};
            default: e.load = rdata;
        endcase
        e.regwrite = !flush && rw && !bad && !e.timeout;
        e.memtoreg = !flush && mtr;
        e.pcsrc    = !flush && br && z;
        e.rd  = rd;
        e.alu = alu;
        e.pcb = pcb;
        e.mis = m_mis;
        if (bad) m_mis = 1'b1;
        if (e.timeout) m_tmo = 1'b1;
        e.tmo = m_tmo;
        exp_q.push_back(e);
        if (e.access) begin
            lat_q.push_back(lat);
            rdata_q.push_back(rdata);
        end
        ALU_OUT_EX = alu; REG_DATA2_EX_FINAL = d; FUNCT3_EX = f3;
        MemRead_EX = rd_en; MemWrite_EX = wr; RegWrite_EX = rw; MemtoReg_EX = mtr;
        Branch_EX = br; ZERO_EX = z; RD_EX = rd; PC_Branch_EX = pcb; flush_ex = flush;
        guard = 0;
        forever begin
            @(negedge clk); #3;
            st = mem_stall;
            @(posedge clk); #1;
            if (!st) break;
            guard++;
            if (guard > 40) begin
                chk("accept_timeout", 32'(guard), 32'd0);
                break;
            end
        end
    endtask

    // Memory responder: a new request takes the next queued latency and
    // read data; ready rises after that many wait cycles.
    initial begin : g_responder
        bit active = 1'b0;
        int cnt = 0, cur_lat = 0;
        forever begin
            @(negedge clk);
            if (!dmem_req) begin
                active = 1'b0;
                dmem_ready = 1'b0;
            end else begin
                if (!active) begin
                    if (lat_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                        cur_lat = 0;
                    end else begin
                        cur_lat = lat_q.pop_front();
                        dmem_rdata = rdata_q.pop_front();
                    end
                    cnt = 0;
                    active = 1'b1;
                end else begin
                    cnt++;
                end
                dmem_ready = (cnt == cur_lat);
                if (dmem_ready) active = 1'b0;
            end
        end
    end

    // Monitor: each unstalled cycle is one instruction leaving MEM.
    initial begin : g_monitor
        int   stall_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (mon_on && rst_n) begin
                if (mem_stall) begin
                    stall_cnt++;
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                    chk("req", {31'd0, dmem_req}, {31'd0, e.access && !e.timeout});
                    if (e.access && !e.timeout) begin
                        chk("we", {31'd0, dmem_we}, {31'd0, e.we});
                        chk("addr", dmem_addr, e.addr);
                        chk("be", {28'd0, dmem_be}, {28'd0, e.be});
                        if (e.we) chk("wdata", dmem_wdata, e.wdata);
                    end
                    if (e.is_load) chk("load_data", LOAD_DATA_MEM, e.load);
                    chk("regwrite", {31'd0, RegWrite_MEM}, {31'd0, e.regwrite});
                    chk("memtoreg", {31'd0, MemtoReg_MEM}, {31'd0, e.memtoreg});
                    chk("pcsrc", {31'd0, PCSrc_MEM}, {31'd0, e.pcsrc});
                    if (!e.bubble) begin
                        chk("rd", {27'd0, RD_MEM}, {27'd0, e.rd});
                        chk("alu_out", ALU_OUT_MEM, e.alu);
                        chk("pc_branch", PC_Branch_MEM, e.pcb);
                    end
                    chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
                    chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.tmo});
                    stall_cnt = 0;
                end else begin
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin : g_stimulus
        exp_t        rst_e;
        logic [31:0] a;
        int          lat, guard;
        // Reset state, with live-looking EX inputs held during reset.
        ALU_OUT_EX = 32'h1234_5678; MemRead_EX = 1'b1; RegWrite_EX = 1'b1;
        Branch_EX = 1'b1; ZERO_EX = 1'b1; RD_EX = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_alu", ALU_OUT_MEM, 32'd0);
        chk("rst_rd", {27'd0, RD_MEM}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWrite_MEM}, 32'd0);
        chk("rst_pcsrc", {31'd0, PCSrc_MEM}, 32'd0);
        chk("rst_pcb", PC_Branch_MEM, 32'd0);
        chk("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
        rst_n = 1'b1;
        rst_e = '{bubble: 1'b1, default: '0};
        exp_q.push_back(rst_e);
        mon_on = 1'b1;

        //    alu           data          f3    rd we rw mt br z  rd     pcb          fl lat    rdata
        issue(32'h100, 32'hDEADBEEF,   3'd2, 0, 1, 0, 0, 0, 0, 5'd0,  32'h0,        0, 0,     32'h0);
        issue(32'h103, 32'h0,          3'd0, 1, 0, 1, 1, 0, 0, 5'd1,  32'h0,        0, 2,     32'h80123456);
        issue(32'h103, 32'h0,          3'd4, 1, 0, 1, 1, 0, 0, 5'd2,  32'h0,        0, 2,     32'h80123456);
        issue(32'h102, 32'h00001234,   3'd1, 0, 1, 0, 0, 0, 0, 5'd0,  32'h0,        0, 1,     32'h0);
        issue(32'h101, 32'h0,          3'd2, 1, 0, 1, 1, 0, 0, 5'd3,  32'h0,        0, 0,     32'h0);
        issue(32'h200, 32'h0,          3'd2, 1, 0, 1, 1, 0, 0, 5'd4,  32'h0,        0, 255,   32'h0);
        issue(32'h0,   32'h0,          3'd0, 0, 0, 1, 0, 1, 1, 5'd5,  32'h0000_4000, 0, 0,    32'h0);
        issue(32'h206, 32'h0,          3'd1, 1, 0, 1, 1, 0, 0, 5'd6,  32'h0,        0, MAXW,  32'h80017FFF);
        issue(32'h206, 32'h0,          3'd5, 1, 0, 1, 1, 0, 0, 5'd7,  32'h0,        0, 3,     32'h80017FFF);
        issue(32'h300, 32'h55,         3'd4, 0, 1, 0, 0, 0, 0, 5'd0,  32'h0,        0, 0,     32'h0);
        issue(32'h301, 32'hA5,         3'd0, 1, 1, 1, 0, 0, 0, 5'd8,  32'h0,        0, 1,     32'h0);
        issue(32'h0,   32'h0,          3'd0, 1, 1, 1, 1, 1, 1, 5'd9,  32'h0,        1, 0,     32'h0);

        for (int i = 0; i < 250; i++) begin
            a   = $urandom;
            lat = int'($urandom_range(0, MAXW + 1));
            if (lat == MAXW + 1) lat = 255;
            issue(a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  $urandom, ($urandom_range(0, 7) == 0), lat, $urandom);
        end

        // Drain with bubbles until every prediction has been compared.
        flush_ex = 1'b1; MemRead_EX = 1'b0; MemWrite_EX = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        mon_on = 1'b0;

        // Asynchronous reset in the middle of a wait.
        lat_q.push_back(255);
        rdata_q.push_back(32'h0);
        @(negedge clk);
        ALU_OUT_EX = 32'h400; FUNCT3_EX = 3'd2; MemRead_EX = 1'b1; flush_ex = 1'b0;
        @(posedge clk); #1;
        MemRead_EX = 1'b0; flush_ex = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("midwait_stall", {31'd0, mem_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwait_req", {31'd0, dmem_req}, 32'd0);
        chk("rstwait_stall", {31'd0, mem_stall}, 32'd0);
        chk("rstwait_errs", {30'd0, misalign_err, timeout_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
